writeback_address_generator: RTL and testbench

- Write-side counterpart to the address generator on the LDPC message memory.
- Captures each read address the address generator issues while a node-processor read is in flight. Replays those addresses in order as write addresses when the processor returns results.
- Signals end of frame after FRAME_LEN writes.
- Sits between the address generator output, the node-processing pipeline's result-valid, and the message-memory write port.

---
 rtl/writeback_address_generator.sv | 142 ++++++++++++++
 tb/tb_writeback_address_generator.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_address_generator.sv
// writeback_address_generator
//
// Captures read addresses issued by the LDPC message-memory address generator
// while node-processor reads are in flight, then replays them in order as
// write addresses when the processor returns results. Pulses frame_done with
// every FRAME_LEN-th write.
//
// Optional feature: define WBAG_BYPASS_EN to forward rd_addr straight to the
// write port when the FIFO is empty and a read and a result coincide.
// Without the macro, the read is stored and the result is flagged as underflow.

module writeback_address_generator #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int FRAME_LEN  = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clr,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         rd_addr,
  input  logic                          res_valid,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wr_addr,
  output logic                          frame_done,
  output logic                          ovf,
  output logic                          unf
);

  localparam int                 PTR_W     = $clog2(FIFO_DEPTH);
  localparam int                 LVL_W     = PTR_W + 1;
  localparam logic [LVL_W-1:0]   DEPTH_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [15:0]        LAST_IDX  = 16'(FRAME_LEN - 1);

  // Pointers carry one extra wrap bit so their difference is the occupancy.
  logic [LVL_W-1:0]      wr_ptr;
  logic [LVL_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [15:0]           frame_cnt;

  logic                  push;
  logic                  pop;
  logic                  bypass;
  logic                  write_now;
  logic [DATA_WIDTH-1:0] write_data;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == DEPTH_LVL);
  assign empty = (level == '0);

  // Accept/reject decisions use start-of-cycle full/empty; clr suppresses both.
  always_comb begin
    bypass     = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    write_now  = 1'b0;
    write_data = mem[rd_ptr[PTR_W-1:0]];
`ifdef WBAG_BYPASS_EN
    bypass     = !clr && empty && in_valid && res_valid;
`endif
    push       = !clr && in_valid && !full && !bypass;
    pop        = !clr && res_valid && !empty;
    write_now  = pop || bypass;
    if (bypass) begin
      write_data = rd_addr;
    end
  end

  // FIFO pointer update; reset and clr both drop every stored address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Address storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= rd_addr;
    end
  end

  // Registered write port and frame counter, one cycle after the pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else if (clr) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      wr_en      <= write_now;
      frame_done <= 1'b0;
      if (write_now) begin
        wr_addr <= write_data;
        if (frame_cnt == LAST_IDX) begin
          frame_cnt  <= '0;
          frame_done <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + 16'd1;
        end
      end
    end
  end

  // Sticky error flags, cleared only by reset or clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (clr) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (in_valid && full) begin
        ovf <= 1'b1;
      end
      if (res_valid && empty && !bypass) begin
        unf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_writeback_address_generator.sv
// Testbench for writeback_address_generator: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// queue-based reference model.

module tb_writeback_address_generator;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int FLEN  = 12;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          clr       = 1'b0;
  logic          in_valid  = 1'b0;
  logic [DW-1:0] rd_addr   = '0;
  logic          res_valid = 1'b0;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          wr_en;
  logic [DW-1:0] wr_addr;
  logic          frame_done;
  logic          ovf;
  logic          unf;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Reference model state
  logic [DW-1:0] mq[$];
  bit            m_wr_en;
  logic [DW-1:0] m_wr_addr;
  bit            m_fd;
  bit            m_ovf;
  bit            m_unf;
  int            m_writes;

  always #5 clk = ~clk;

  writeback_address_generator #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .FRAME_LEN (FLEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .in_valid  (in_valid),
    .rd_addr   (rd_addr),
    .res_valid (res_valid),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .frame_done(frame_done),
    .ovf       (ovf),
    .unf       (unf)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d time=%0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge and are consumed by the next edge.
  task automatic applyStimulus(input bit iv, input logic [DW-1:0] a, input bit rv, input bit c);
    in_valid  = iv;
    rd_addr   = a;
    res_valid = rv;
    clr       = c;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: a queue of pending addresses and a running write count.
  always @(posedge clk or negedge reset) begin
    bit            was_full;
    bit            was_empty;
    bit            byp;
    bit            wr;
    logic [DW-1:0] addr;
    if (!reset || clr) begin
      mq.delete();
      m_wr_en   = 1'b0;
      m_wr_addr = '0;
      m_fd      = 1'b0;
      m_ovf     = 1'b0;
      m_unf     = 1'b0;
      m_writes  = 0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      byp       = 1'b0;
`ifdef WBAG_BYPASS_EN
      byp = was_empty && in_valid && res_valid;
`endif
      wr   = 1'b0;
      addr = '0;
      if (byp) begin
        wr   = 1'b1;
        addr = rd_addr;
      end else begin
        if (res_valid) begin
          if (was_empty) m_unf = 1'b1;
          else begin
            addr = mq.pop_front();
            wr   = 1'b1;
          end
        end
        if (in_valid) begin
          if (was_full) m_ovf = 1'b1;
          else mq.push_back(rd_addr);
        end
      end
      m_wr_en = wr;
      m_fd    = 1'b0;
      if (wr) begin
        m_wr_addr = addr;
        m_writes++;
        m_fd = ((m_writes % FLEN) == 0);
      end
    end
  end

  // Every-cycle comparison of the DUT against the model, away from the rising edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("m_wr_en", int'(wr_en), int'(m_wr_en));
      checkOutput("m_wr_addr", int'(wr_addr), int'(m_wr_addr));
      checkOutput("m_frame_done", int'(frame_done), int'(m_fd));
      checkOutput("m_level", int'(level), mq.size());
      checkOutput("m_full", int'(full), int'(mq.size() == DEPTH));
      checkOutput("m_empty", int'(empty), int'(mq.size() == 0));
      checkOutput("m_ovf", int'(ovf), int'(m_ovf));
      checkOutput("m_unf", int'(unf), int'(m_unf));
    end
  end

  initial begin
    // Reset values
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b1;
    checkOutput("rst_level", int'(level), 0);
    checkOutput("rst_empty", int'(empty), 1);
    checkOutput("rst_full", int'(full), 0);
    checkOutput("rst_wr_en", int'(wr_en), 0);
    checkOutput("rst_wr_addr", int'(wr_addr), 0);
    checkOutput("rst_frame_done", int'(frame_done), 0);
    checkOutput("rst_ovf", int'(ovf), 0);
    checkOutput("rst_unf", int'(unf), 0);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0);

    // Three pushes then three pops replay in order
    applyStimulus(1, 8'd12, 0, 0);
    applyStimulus(1, 8'd11, 0, 0);
    applyStimulus(1, 8'd10, 0, 0);
    checkOutput("seq_level3", int'(level), 3);
    applyStimulus(0, 0, 1, 0);
    checkOutput("seq_wr_en0", int'(wr_en), 1);
    checkOutput("seq_addr0", int'(wr_addr), 12);
    applyStimulus(0, 0, 1, 0);
    checkOutput("seq_addr1", int'(wr_addr), 11);
    applyStimulus(0, 0, 1, 0);
    checkOutput("seq_addr2", int'(wr_addr), 10);
    checkOutput("seq_level0", int'(level), 0);
    checkOutput("seq_empty", int'(empty), 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("seq_idle_wr_en", int'(wr_en), 0);
    checkOutput("seq_hold_addr", int'(wr_addr), 10);

    // Fill to full, overflow, drain
    applyStimulus(0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, DW'(i), 0, 0);
    checkOutput("fill_full", int'(full), 1);
    applyStimulus(1, 8'd99, 0, 0);
    checkOutput("fill_ovf", int'(ovf), 1);
    checkOutput("fill_level", int'(level), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 0, 1, 0);
      checkOutput("drain_addr", int'(wr_addr), i);
    end
    checkOutput("drain_empty", int'(empty), 1);

    // Underflow then clr
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("unf_set", int'(unf), 1);
    checkOutput("unf_wr_en", int'(wr_en), 0);
    checkOutput("unf_level", int'(level), 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("unf_clr", int'(unf), 0);

    // Streamed frame of 12 writes, addresses 12 down to 1
    applyStimulus(1, 8'd12, 0, 0);
    for (int k = 1; k < FLEN; k++) begin
      applyStimulus(1, DW'(12 - k), 1, 0);
      checkOutput("frame_addr", int'(wr_addr), 13 - k);
      checkOutput("frame_early_done", int'(frame_done), 0);
    end
    applyStimulus(0, 0, 1, 0);
    checkOutput("frame_last_addr", int'(wr_addr), 1);
    checkOutput("frame_done_pulse", int'(frame_done), 1);
    applyStimulus(1, 8'd50, 0, 0);
    checkOutput("frame_done_low", int'(frame_done), 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("frame13_addr", int'(wr_addr), 50);
    checkOutput("frame13_done", int'(frame_done), 0);

    // Reset mid-stream
    applyStimulus(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1, DW'(100 + i), 0, 0);
    checkOutput("mid_level5", int'(level), 5);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_level", int'(level), 0);
    checkOutput("mid_rst_empty", int'(empty), 1);
    checkOutput("mid_rst_wr_en", int'(wr_en), 0);
    checkOutput("mid_rst_wr_addr", int'(wr_addr), 0);
    reset = 1'b1;
    applyStimulus(0, 0, 1, 0);
    checkOutput("mid_unf", int'(unf), 1);
    checkOutput("mid_wr_en", int'(wr_en), 0);

    // Simultaneous read and result on an empty FIFO
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 8'd42, 1, 0);
`ifdef WBAG_BYPASS_EN
    checkOutput("byp_wr_en", int'(wr_en), 1);
    checkOutput("byp_addr", int'(wr_addr), 42);
    checkOutput("byp_level", int'(level), 0);
    checkOutput("byp_unf", int'(unf), 0);
`else
    checkOutput("nobyp_wr_en", int'(wr_en), 0);
    checkOutput("nobyp_level", int'(level), 1);
    checkOutput("nobyp_unf", int'(unf), 1);
`endif
    applyStimulus(0, 0, 0, 1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0);
        reset = 1'b1;
      end else begin
        applyStimulus($urandom_range(0, 99) < 55, DW'($urandom), $urandom_range(0, 99) < 50,
                      $urandom_range(0, 199) == 0);
      end
    end
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
